// File: rtl/pin_entry_if.sv
// Keypad/PIN bus between the keypad front end and its environment.
// The master drives key strobes and PIN loads; the slave (the checker) returns verdicts.
interface pin_entry_if #(
   parameter int DIGITS = 4
) ();

   localparam int CNT_W = $clog2(DIGITS + 1);

   logic                  key_valid_i;
   logic [3:0]            key_code_i;
   logic                  pin_load_i;
   logic [4*DIGITS-1:0]   pin_value_i;
   logic                  pin_correct_o;
   logic                  pin_wrong_o;
   logic                  lockout_o;
   logic [CNT_W-1:0]      digit_count_o;

   modport master (
      output key_valid_i, key_code_i, pin_load_i, pin_value_i,
      input  pin_correct_o, pin_wrong_o, lockout_o, digit_count_o
   );

   modport slave (
      input  key_valid_i, key_code_i, pin_load_i, pin_value_i,
      output pin_correct_o, pin_wrong_o, lockout_o, digit_count_o
   );

endinterface

// File: rtl/pin_entry_checker.sv
// Keypad front end for the door-lock controller: collects a DIGITS-long BCD entry,
// compares it against the stored PIN and pulses pin_correct / pin_wrong.
// Abandons an entry after TIMEOUT_CYC idle cycles and locks the keypad for
// LOCKOUT_CYC cycles after MAX_TRIES consecutive failures.
module pin_entry_checker #(
   parameter int DIGITS      = 4,
   parameter int MAX_TRIES   = 3,
   parameter int TIMEOUT_CYC = 1000,
   parameter int LOCKOUT_CYC = 5000
) (
   input  logic        clk,
   input  logic        rst,
   pin_entry_if.slave  bus
);

   localparam int BUF_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam int FC_W  = $clog2(MAX_TRIES + 1);
   localparam int TMR_MAX = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
   localparam int TMR_W = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] LOCKOUT_LAST = TMR_W'(LOCKOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(DIGITS);
   localparam logic [FC_W-1:0]  FAIL_LIMIT   = FC_W'(MAX_TRIES);

   localparam logic [3:0] KEY_CLR = 4'hE;
   localparam logic [3:0] KEY_ENT = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_CHECK,
      S_LOCKOUT
   } state_t;

   state_t             state_q,   state_d;
   logic [BUF_W-1:0]   pin_q,     pin_d;
   logic [BUF_W-1:0]   buf_q,     buf_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic               ovf_q,     ovf_d;
   logic [FC_W-1:0]    fail_q,    fail_d;
   logic [TMR_W-1:0]   tmr_q,     tmr_d;
   logic               correct_q, correct_d;
   logic               wrong_q,   wrong_d;
   logic               lock_q,    lock_d;

   logic               is_digit;
   logic               is_clr;
   logic               is_ent;
   logic               match;
   logic [FC_W-1:0]    fail_inc;
   logic [BUF_W-1:0]   key_ext;

   // Key decode and entry-vs-stored comparison.
   always_comb begin
      is_digit = bus.key_valid_i && (bus.key_code_i <= 4'd9);
      is_clr   = bus.key_valid_i && (bus.key_code_i == KEY_CLR);
      is_ent   = bus.key_valid_i && (bus.key_code_i == KEY_ENT);
      key_ext       = '0;
      key_ext[3:0]  = bus.key_code_i;
      match    = (cnt_q == CNT_FULL) && !ovf_q && (buf_q == pin_q);
      fail_inc = fail_q + FC_W'(1);
   end

   // Next-state and registered-output logic for the entry FSM.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      pin_d     = pin_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      fail_d    = fail_q;
      tmr_d     = tmr_q;
      correct_d = 1'b0;
      wrong_d   = 1'b0;
      lock_d    = lock_q;

      case (state_q)
         S_IDLE: begin
            if (bus.pin_load_i) begin
               pin_d = bus.pin_value_i;
            end
            if (is_digit) begin
               buf_d   = key_ext;
               cnt_d   = CNT_W'(1);
               tmr_d   = '0;
               state_d = S_ENTRY;
            end
         end

         S_ENTRY: begin
            if (is_digit) begin
               tmr_d = '0;
               if (cnt_q < CNT_FULL) begin
                  // Earlier digits move toward the MS nibble.
                  buf_d = (buf_q << 4) | key_ext;
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end else if (is_clr) begin
               buf_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_IDLE;
            end else if (is_ent) begin
               state_d = S_CHECK;
            end else if (bus.key_valid_i) begin
               // Reserved codes are still key activity for the idle timer.
               tmr_d = '0;
            end else if (tmr_q == TIMEOUT_LAST) begin
               // Abandoned entry: discarded silently, not counted as an attempt.
               buf_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               tmr_d   = '0;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         S_CHECK: begin
            buf_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            if (match) begin
               correct_d = 1'b1;
               fail_d    = '0;
               state_d   = S_IDLE;
            end else begin
               wrong_d = 1'b1;
               fail_d  = fail_inc;
               if (fail_inc == FAIL_LIMIT) begin
                  lock_d  = 1'b1;
                  tmr_d   = '0;
                  state_d = S_LOCKOUT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_LOCKOUT: begin
            if (tmr_q == LOCKOUT_LAST) begin
               lock_d  = 1'b0;
               fail_d  = '0;
               tmr_d   = '0;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; stored PIN also returns to 0 on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pin_q     <= '0;
         buf_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         fail_q    <= '0;
         tmr_q     <= '0;
         correct_q <= 1'b0;
         wrong_q   <= 1'b0;
         lock_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the values from before this edge.
         state_q   <= state_d;
         pin_q     <= pin_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         fail_q    <= fail_d;
         tmr_q     <= tmr_d;
         correct_q <= correct_d;
         wrong_q   <= wrong_d;
         lock_q    <= lock_d;
      end
   end

   assign bus.pin_correct_o = correct_q;
   assign bus.pin_wrong_o   = wrong_q;
   assign bus.lockout_o     = lock_q;
   assign bus.digit_count_o = cnt_q;

endmodule
